// File: rtl/bram_seq_pkg.sv
// Shared types for the backup-RAM sector sequencer: FSM state encoding and slot-index width.
package bram_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_END  = 2'd3
  } state_t;

  function automatic int slot_w(input int slots);
    return (slots <= 1) ? 1 : $clog2(slots);
  endfunction

endpackage

// File: rtl/bram_seq_timer.sv
// Watchdog counter: cleared on restart, counts while run is high, saturates at TIMEOUT.
// expired is decoded from the count register, so it rises the cycle after the final increment.
module bram_seq_timer #(
  parameter int TIMEOUT = 1 << 24
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic restart,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;

  assign expired = (r_cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (restart) begin
      r_cnt <= '0;
    end else if (run && !expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bram_sector_seq.sv
// Streams one save slot of backup RAM to/from SD, one sector per sd_rd/sd_wr handshake.
// Each sector waits indefinitely on sd_ack, bounded by the watchdog; busy is combinational, the rest registered.
module bram_sector_seq
  import bram_seq_pkg::*;
#(
  parameter  int SECTORS = 128,
  parameter  int SLOTS   = 1,
  parameter  int TIMEOUT = 1 << 24,
  localparam int SLOT_W  = slot_w(SLOTS)
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              load_req,
  input  logic              save_req,
  input  logic              mount_load,
  input  logic              change,
  input  logic              osd_open,
  input  logic              autosave_en,
  input  logic [SLOT_W-1:0] slot,
  output logic [31:0]       sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  input  logic              sd_ack,
  output logic              loading,
  output logic              busy,
  output logic              pending,
  output logic              done,
  output logic              error
);

  localparam logic [31:0] LAST_OFS = 32'(SECTORS - 1);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_lba, w_lba_nxt;
  logic [31:0] r_base, w_base_nxt;
  logic        r_rd, w_rd_nxt;
  logic        r_wr, w_wr_nxt;
  logic        r_loading, w_loading_nxt;
  logic        r_pending, w_pending_nxt;
  logic        r_done, w_done_nxt;
  logic        r_error, w_error_nxt;
  logic        r_load_d, r_save_d, r_arm;

  logic        w_save_lvl, w_save_trig, w_load_trig, w_save_start;
  logic        w_expired, w_restart, w_run;
  logic [31:0] w_slot_base;

  // r_arm masks the first cycle after reset so levels already high then are absorbed into the edge history.
  assign w_save_lvl  = save_req | (r_pending & osd_open & autosave_en);
  assign w_save_trig = r_arm & w_save_lvl & ~r_save_d;
  assign w_load_trig = r_arm & ((load_req & ~r_load_d) | mount_load);
  assign w_slot_base = 32'(slot) * 32'(SECTORS);

  assign w_restart = (w_state_nxt != r_state);
  assign w_run     = (r_state == ST_REQ) || (r_state == ST_XFER);

  bram_seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .restart (w_restart),
    .run     (w_run),
    .expired (w_expired)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_lba_nxt     = r_lba;
    w_base_nxt    = r_base;
    w_rd_nxt      = r_rd;
    w_wr_nxt      = r_wr;
    w_loading_nxt = r_loading;
    w_done_nxt    = 1'b0;
    w_error_nxt   = r_error;
    w_save_start  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable && (w_load_trig || w_save_trig)) begin
          w_state_nxt   = ST_REQ;
          w_base_nxt    = w_slot_base;
          w_lba_nxt     = w_slot_base;
          w_loading_nxt = w_load_trig;
          w_rd_nxt      = w_load_trig;
          w_wr_nxt      = ~w_load_trig;
          w_error_nxt   = 1'b0;
          w_save_start  = ~w_load_trig;
        end
      end
      ST_REQ, ST_XFER: begin
        if (w_expired) begin
          w_state_nxt   = ST_IDLE;
          w_rd_nxt      = 1'b0;
          w_wr_nxt      = 1'b0;
          w_loading_nxt = 1'b0;
          w_error_nxt   = 1'b1;
        end else if (r_state == ST_REQ) begin
          if (sd_ack) begin
            w_state_nxt = ST_XFER;
            w_rd_nxt    = 1'b0;
            w_wr_nxt    = 1'b0;
          end
        end else if (!sd_ack) begin
          if ((r_lba - r_base) == LAST_OFS) begin
            w_state_nxt = ST_END;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_REQ;
            w_lba_nxt   = r_lba + 32'd1;
            w_rd_nxt    = r_loading;
            w_wr_nxt    = ~r_loading;
          end
        end
      end
      ST_END: begin
        w_state_nxt   = ST_IDLE;
        w_loading_nxt = 1'b0;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // A fresh change outranks the clear from a save starting in the same cycle.
    w_pending_nxt = (change & ~osd_open) ? 1'b1 : (w_save_start ? 1'b0 : r_pending);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_lba     <= '0;
      r_base    <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_loading <= 1'b0;
      r_pending <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_load_d  <= 1'b0;
      r_save_d  <= 1'b0;
      r_arm     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_lba     <= w_lba_nxt;
      r_base    <= w_base_nxt;
      r_rd      <= w_rd_nxt;
      r_wr      <= w_wr_nxt;
      r_loading <= w_loading_nxt;
      r_pending <= w_pending_nxt;
      r_done    <= w_done_nxt;
      r_error   <= w_error_nxt;
      r_load_d  <= load_req;
      r_save_d  <= w_save_lvl;
      r_arm     <= 1'b1;
    end
  end

  assign sd_lba  = r_lba;
  assign sd_rd   = r_rd;
  assign sd_wr   = r_wr;
  assign loading = r_loading;
  assign pending = r_pending;
  assign done    = r_done;
  assign error   = r_error;
  assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_bram_sector_seq.sv
// Randomized bench for bram_sector_seq: an SD responder with random ack lengths, a sector
// monitor, and expected LBA lists derived directly from slot*SECTORS+i.
module tb_bram_sector_seq;

  localparam int SECTORS = 4;
  localparam int SLOTS   = 2;
  localparam int TIMEOUT = 64;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1, load_req = 1'b0, save_req = 1'b0, mount_load = 1'b0;
  logic        change = 1'b0, osd_open = 1'b0, autosave_en = 1'b0;
  logic [0:0]  slot = 1'b0;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_ack = 1'b0;
  logic        loading, busy, pending, done, error;

  int n_chk = 0, n_pass = 0;

  bit          ack_on = 1'b1;
  int          fixed_len = 0;
  int          ack_cnt = 0;
  logic [31:0] rd_q[$], wr_q[$];
  int          done_cnt = 0, load_seen = 0;
  logic        load_at_done = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0;

  always #5 clk_sys = ~clk_sys;

  bram_sector_seq #(.SECTORS(SECTORS), .SLOTS(SLOTS), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .enable(enable), .load_req(load_req),
    .save_req(save_req), .mount_load(mount_load), .change(change), .osd_open(osd_open),
    .autosave_en(autosave_en), .slot(slot), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .loading(loading), .busy(busy), .pending(pending), .done(done),
    .error(error)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // SD card model and sector monitor, sampled 1ns after each rising edge.
  initial begin
    forever begin
      @(posedge clk_sys);
      #1;
      if (!reset_n) begin
        sd_ack  = 1'b0;
        ack_cnt = 0;
      end else if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) sd_ack = 1'b0;
      end else if (ack_on && (sd_rd || sd_wr) && !sd_ack) begin
        sd_ack  = 1'b1;
        ack_cnt = (fixed_len != 0) ? fixed_len : int'($urandom_range(1, 4));
      end
      if (sd_rd && !prev_rd) rd_q.push_back(sd_lba);
      if (sd_wr && !prev_wr) wr_q.push_back(sd_lba);
      prev_rd = sd_rd;
      prev_wr = sd_wr;
      if (done) begin
        done_cnt++;
        load_at_done = loading;
      end
      if (loading) load_seen++;
    end
  end

  task automatic step();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic clr();
    rd_q.delete();
    wr_q.delete();
    done_cnt  = 0;
    load_seen = 0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (!busy && n < budget) begin step(); n++; end
    while (busy && n < budget) begin step(); n++; end
    check({tag, " finish"}, 32'(busy), 0);
  endtask

  task automatic check_xfer(input string tag, input bit is_load, input int s);
    logic [31:0] base = 32'(s * SECTORS);
    if (is_load) begin
      check({tag, " nrd"}, 32'(rd_q.size()), SECTORS);
      check({tag, " nwr"}, 32'(wr_q.size()), 0);
      for (int i = 0; i < rd_q.size() && i < SECTORS; i++) check({tag, " lba"}, rd_q[i], base + 32'(i));
    end else begin
      check({tag, " nwr"}, 32'(wr_q.size()), SECTORS);
      check({tag, " nrd"}, 32'(rd_q.size()), 0);
      for (int i = 0; i < wr_q.size() && i < SECTORS; i++) check({tag, " lba"}, wr_q[i], base + 32'(i));
    end
    check({tag, " done"}, 32'(done_cnt), 1);
  endtask

  initial begin
    int n;
    bit saw_busy;
    logic [0:0] s;

    // Reset with both request levels high.
    load_req = 1'b1;
    save_req = 1'b1;
    #23;
    check("rst lba", sd_lba, 0);
    check("rst rdwr", {30'd0, sd_rd, sd_wr}, 0);
    check("rst flags", {27'd0, loading, busy, pending, done, error}, 0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("rst no trig", 32'(busy), 0);
    load_req = 1'b0;
    save_req = 1'b0;
    step();

    // Save of slot 1 with 3-cycle acks.
    change = 1'b1;
    step();
    change = 1'b0;
    step();
    check("pend set", 32'(pending), 1);
    clr();
    fixed_len = 3;
    slot = 1'b1;
    save_req = 1'b1;
    wait_idle("save1", 300);
    save_req = 1'b0;
    fixed_len = 0;
    check_xfer("save1", 1'b0, 1);
    check("save1 noload", 32'(load_seen), 0);
    check("save1 pend", 32'(pending), 0);

    // change while the OSD is open does not mark pending.
    osd_open = 1'b1;
    change = 1'b1;
    step();
    change = 1'b0;
    osd_open = 1'b0;
    step();
    check("pend osd", 32'(pending), 0);

    // Autosave on OSD open.
    slot = 1'b0;
    change = 1'b1;
    step();
    change = 1'b0;
    step();
    check("auto pend", 32'(pending), 1);
    clr();
    osd_open = 1'b1;
    autosave_en = 1'b1;
    step();
    check("auto start", 32'(busy), 1);
    check("auto lba0", sd_lba, 0);
    check("auto pclr", 32'(pending), 0);
    wait_idle("auto", 300);
    check_xfer("auto", 1'b0, 0);
    osd_open = 1'b0;
    autosave_en = 1'b0;

    // Cart-download load of slot 0; pending survives a load.
    change = 1'b1;
    step();
    change = 1'b0;
    clr();
    mount_load = 1'b1;
    step();
    mount_load = 1'b0;
    check("mload loading", 32'(loading), 1);
    wait_idle("mload", 300);
    check_xfer("mload", 1'b1, 0);
    check("mload load@end", 32'(load_at_done), 1);
    check("mload loadclr", 32'(loading), 0);
    check("mload pend", 32'(pending), 1);

    // Load and save edges together; re-trigger and slot change mid-transfer.
    s = 1'($urandom_range(0, 1));
    slot = s;
    clr();
    load_req = 1'b1;
    save_req = 1'b1;
    step();
    slot = ~s;
    for (int i = 0; i < 6; i++) step();
    load_req = 1'b0;
    step();
    load_req = 1'b1;
    check("both midbusy", 32'(busy), 1);
    wait_idle("both", 300);
    check_xfer("both", 1'b1, int'(s));
    saw_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin step(); saw_busy |= busy; end
    check("both noqueue", 32'(saw_busy), 0);
    check("both pend", 32'(pending), 1);
    load_req = 1'b0;
    save_req = 1'b0;
    step();

    // Watchdog: no ack at all.
    ack_on = 1'b0;
    slot = 1'b0;
    clr();
    mount_load = 1'b1;
    step();
    mount_load = 1'b0;
    n = 0;
    while (busy && n < 200) begin step(); n++; end
    check("to window", 32'(n >= TIMEOUT && n <= TIMEOUT + 4), 1);
    check("to rdwr", {30'd0, sd_rd, sd_wr}, 0);
    check("to error", 32'(error), 1);
    check("to loading", 32'(loading), 0);
    check("to nodone", 32'(done_cnt), 0);
    ack_on = 1'b1;

    // Next request clears error; simultaneous change keeps pending set.
    clr();
    save_req = 1'b1;
    change = 1'b1;
    step();
    change = 1'b0;
    check("retry errclr", 32'(error), 0);
    check("retry pend", 32'(pending), 1);
    wait_idle("retry", 300);
    check_xfer("retry", 1'b0, 0);
    save_req = 1'b0;
    step();

    // Asynchronous reset during sector 2 of a load.
    slot = 1'b1;
    clr();
    mount_load = 1'b1;
    step();
    mount_load = 1'b0;
    n = 0;
    while (rd_q.size() < 3 && n < 200) begin step(); n++; end
    check("mid sector2", 32'(rd_q.size()), 3);
    reset_n = 1'b0;
    #1;
    check("mid rst lba", sd_lba, 0);
    check("mid rst rdwr", {30'd0, sd_rd, sd_wr}, 0);
    check("mid rst flags", {27'd0, loading, busy, pending, done, error}, 0);
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("mid nodone", 32'(done_cnt), 0);
    check("mid idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1);
  end

endmodule
